// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset/lock supervisor and the rest of the design.
// master = the sequencer, slave = the consumer of its status.
interface pll_reset_sequencer_if;
  logic       locked;
  logic       restart;
  logic       pll_reset;
  logic       clocks_ok;
  logic       sys_reset_n;
  logic       lock_lost;
  logic       failed;
  logic [7:0] retry_count;

  modport master (
    input  locked, restart,
    output pll_reset, clocks_ok, sys_reset_n, lock_lost, failed, retry_count
  );

  modport slave (
    output locked, restart,
    input  pll_reset, clocks_ok, sys_reset_n, lock_lost, failed, retry_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse generator and lock qualifier: retries on lock timeout, holds the
// system in reset until LOCKED has been stable, and reports loss/retries/failure.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input  logic                   clk_in50mhz,
  input  logic                   reset_n,
  pll_reset_sequencer_if.master  seq
);

  localparam logic [19:0] RST_LAST     = 20'(RST_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] STABLE_LAST  = 20'(STABLE_CYCLES - 1);
  localparam logic [7:0]  RETRY_LIMIT  = (MAX_RETRIES > 255) ? 8'hFF : 8'(MAX_RETRIES);
  localparam bit          RETRY_FOREVER = (MAX_RETRIES == 0);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] count_q, count_d;
  logic [7:0]  retry_q, retry_d;
  logic        lost_q, lost_d;
  logic [1:0]  sync_q;
  logic        locked_s;
  logic        pll_reset_q;
  logic        clocks_ok_q;
  logic        failed_q;

  always_ff @(posedge clk_in50mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], seq.locked};
    end
  end

  assign locked_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    count_d = count_q + 20'd1;
    retry_d = retry_q;
    lost_d  = lost_q;

    if (seq.restart) begin
      state_d = S_RESET;
      count_d = '0;
      retry_d = '0;
      lost_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_RESET: begin
          if (count_q == RST_LAST) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (locked_s) begin
            state_d = S_STABLE;
          end else if (count_q == TIMEOUT_LAST) begin
            if (!RETRY_FOREVER && (retry_q >= RETRY_LIMIT)) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RESET;
              retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
            end
          end
        end
        S_STABLE: begin
          // A drop beats the terminal count and reopens a full timeout window.
          if (!locked_s) begin
            state_d = S_WAIT;
          end else if (count_q == STABLE_LAST) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          count_d = '0;
          if (!locked_s) begin
            state_d = S_RESET;
            lost_d  = 1'b1;
          end
        end
        S_FAIL: begin
          count_d = '0;
        end
        default: begin
          state_d = S_RESET;
        end
      endcase
    end

    if (state_d != state_q) count_d = '0;
  end

  // Outputs are decoded from the next state so they move on the same edge as the FSM.
  always_ff @(posedge clk_in50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RESET;
      count_q     <= '0;
      retry_q     <= '0;
      lost_q      <= 1'b0;
      pll_reset_q <= 1'b1;
      clocks_ok_q <= 1'b0;
      failed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      pll_reset_q <= (state_d == S_RESET) || (state_d == S_FAIL);
      clocks_ok_q <= (state_d == S_RUN);
      failed_q    <= (state_d == S_FAIL);
    end
  end

  assign seq.pll_reset   = pll_reset_q;
  assign seq.clocks_ok   = clocks_ok_q;
  assign seq.sys_reset_n = clocks_ok_q;
  assign seq.lock_lost   = lost_q;
  assign seq.failed      = failed_q;
  assign seq.retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: phase/deadline model checked every cycle,
// plus directed scenarios with hand-computed widths and latencies.
module tb_pll_reset_sequencer;

  localparam int RST  = 4;
  localparam int TMO  = 20;
  localparam int STB  = 8;
  localparam int MAXR = 2;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;
  bit   chk_en;
  int   c;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (TMO),
    .STABLE_CYCLES (STB),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .clk_in50mhz (clk),
    .reset_n     (reset_n),
    .seq         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a phase plus the number of cycles left before its deadline.
  typedef enum {PULSE, LISTEN, QUALIFY, LIVE, DEAD} phase_t;
  phase_t m_phase;
  int     m_left;
  int     m_retries;
  bit     m_lost;
  bit     m_s1, m_s2;

  task automatic model_reset();
    m_phase   = PULSE;
    m_left    = RST;
    m_retries = 0;
    m_lost    = 0;
    m_s1      = 0;
    m_s2      = 0;
  endtask

  task automatic model_step();
    bit ls;
    ls = m_s2;
    if (bus.restart) begin
      m_phase = PULSE; m_left = RST; m_retries = 0; m_lost = 0;
    end else begin
      case (m_phase)
        PULSE: begin
          m_left--;
          if (m_left == 0) begin m_phase = LISTEN; m_left = TMO; end
        end
        LISTEN: begin
          if (ls) begin
            m_phase = QUALIFY; m_left = STB;
          end else begin
            m_left--;
            if (m_left == 0) begin
              if (MAXR != 0 && m_retries >= MAXR) m_phase = DEAD;
              else begin
                m_retries = (m_retries < 255) ? m_retries + 1 : 255;
                m_phase = PULSE; m_left = RST;
              end
            end
          end
        end
        QUALIFY: begin
          if (!ls) begin
            m_phase = LISTEN; m_left = TMO;
          end else begin
            m_left--;
            if (m_left == 0) m_phase = LIVE;
          end
        end
        LIVE: begin
          if (!ls) begin m_lost = 1; m_phase = PULSE; m_left = RST; end
        end
        default: ;
      endcase
    end
    m_s2 = m_s1;
    m_s1 = bus.locked;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    #1;
    if (!reset_n) model_reset();
    else model_step();
    if (chk_en) begin
      check("m_pll_reset", 32'(bus.pll_reset), 32'(m_phase == PULSE || m_phase == DEAD));
      check("m_clocks_ok", 32'(bus.clocks_ok), 32'(m_phase == LIVE));
      check("m_sys_reset_n", 32'(bus.sys_reset_n), 32'(m_phase == LIVE));
      check("m_failed", 32'(bus.failed), 32'(m_phase == DEAD));
      check("m_lock_lost", 32'(bus.lock_lost), 32'(m_lost));
      check("m_retry_count", 32'(bus.retry_count), 32'(m_retries));
    end
  end

  task automatic count_until(input logic lvl, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.pll_reset == lvl && n < 200);
  endtask

  task automatic edges_until_ok(input logic lvl, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.clocks_ok != lvl && n < 200);
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_reset"}, 32'(bus.pll_reset), 1);
    check({tag, "_clocks_ok"}, 32'(bus.clocks_ok), 0);
    check({tag, "_sys_reset_n"}, 32'(bus.sys_reset_n), 0);
    check({tag, "_lock_lost"}, 32'(bus.lock_lost), 0);
    check({tag, "_failed"}, 32'(bus.failed), 0);
    check({tag, "_retry"}, 32'(bus.retry_count), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0; chk_en = 0;
    reset_n = 1'b0; bus.locked = 1'b0; bus.restart = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    chk_en = 1;

    // 1: normal bring-up
    @(negedge clk); reset_n = 1'b1;
    count_until(1'b1, c); check("c1_pulse_width", 32'(c), 4);
    repeat (2) @(negedge clk); bus.locked = 1'b1;
    @(negedge clk);
    edges_until_ok(1'b1, c); check("c1_ok_latency", 32'(c), 10);
    check("c1_sys_reset_n", 32'(bus.sys_reset_n), 1);
    check("c1_retry", 32'(bus.retry_count), 0);
    check("c1_lock_lost", 32'(bus.lock_lost), 0);

    // 2: never locks -> three pulses, then FAIL
    @(negedge clk); reset_n = 1'b0; bus.locked = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      count_until(1'b1, c); check("c2_high_width", 32'(c), 4);
      count_until(1'b0, c); check("c2_low_width", 32'(c), 20);
      if (i < 2) check("c2_retry_step", 32'(bus.retry_count), 32'(i + 1));
    end
    check("c2_failed", 32'(bus.failed), 1);
    check("c2_pll_reset", 32'(bus.pll_reset), 1);
    check("c2_retry_final", 32'(bus.retry_count), 2);
    repeat (30) @(negedge clk);
    check("c2_failed_held", 32'(bus.failed), 1);
    check("c2_pll_reset_held", 32'(bus.pll_reset), 1);

    // 3: restart out of FAIL
    pulse_restart();
    check("c3_failed_clr", 32'(bus.failed), 0);
    check("c3_retry_clr", 32'(bus.retry_count), 0);
    check("c3_pll_reset", 32'(bus.pll_reset), 1);
    bus.locked = 1'b1;
    edges_until_ok(1'b1, c);
    check("c3_clocks_ok", 32'(bus.clocks_ok), 1);

    // 4: lock loss in RUN for 5 cycles
    repeat (4) @(negedge clk);
    bus.locked = 1'b0;
    edges_until_ok(1'b0, c); check("c4_drop_latency", 32'(c), 3);
    check("c4_lock_lost", 32'(bus.lock_lost), 1);
    check("c4_retry", 32'(bus.retry_count), 0);
    fork
      begin repeat (2) @(negedge clk); bus.locked = 1'b1; end
      begin count_until(1'b1, c); end
    join
    check("c4_pulse_width", 32'(c), 4);
    edges_until_ok(1'b1, c);
    check("c4_requal", 32'(bus.clocks_ok), 1);
    check("c4_lost_sticky", 32'(bus.lock_lost), 1);

    // 5: 2-cycle drop at STABLE count 5
    pulse_restart();
    repeat (10) @(negedge clk);
    check("c5_not_yet_ok", 32'(bus.clocks_ok), 0);
    bus.locked = 1'b0;
    repeat (2) @(negedge clk);
    bus.locked = 1'b1;
    @(negedge clk);
    edges_until_ok(1'b1, c); check("c5_full_requal", 32'(c), 10);

    // 6: asynchronous reset in STABLE and in RUN
    pulse_restart();
    repeat (7) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_values("c6_stable");
    @(negedge clk); reset_n = 1'b1;
    edges_until_ok(1'b1, c);
    check("c6_restart_ok", 32'(bus.clocks_ok), 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_values("c6_run");
    @(negedge clk); reset_n = 1'b1;
    edges_until_ok(1'b1, c);
    check("c6_run_restart_ok", 32'(bus.clocks_ok), 1);

    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
